// File: rtl/avst_frame_writer.sv
// rtl/avst_frame_writer.sv - Avalon-ST RGB pixel sink writing packed pixels into the frame buffer.
// Optional luma output when FRAME_WRITER_GRAY_EN is defined.
module avst_frame_writer #(
    parameter int COLS   = 320,
    parameter int ROWS   = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_startofpacket,
    input  logic              sink_endofpacket,
    input  logic              freeze,
    output logic [ADDR_W-1:0] wraddress,
    output logic [11:0]       wrdata,
    output logic              wren,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP, S_FROZEN} state_t;

    localparam int NPIX = COLS * ROWS;
    // ptr is one bit wider than the address so it can hold "all pixels written"
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W+1)'(NPIX - 1);
    localparam logic [ADDR_W:0] PIX_FULL = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam bit              ONE_PIX  = (NPIX == 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [11:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;
    logic [11:0]       pix;
    logic              acc;

`ifdef FRAME_WRITER_GRAY_EN
    logic [17:0] y_sum;
    logic        unused_bits;
    assign y_sum = 18'd77  * {8'd0, sink_data[29:20]}
                 + 18'd150 * {8'd0, sink_data[19:10]}
                 + 18'd29  * {8'd0, sink_data[9:0]};
    // Y = y_sum >> 8, so Y[9:6] is y_sum[17:14]
    assign pix         = {3{y_sum[17:14]}};
    assign unused_bits = ^y_sum[13:0];
`else
    logic unused_bits;
    assign pix         = {sink_data[29:26], sink_data[19:16], sink_data[9:6]};
    assign unused_bits = ^{sink_data[25:20], sink_data[15:10], sink_data[5:0]};
`endif

    assign acc = sink_valid & ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wren_d  = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_DROP: begin
                if (acc) begin
                    if (sink_startofpacket) begin
                        wren_d  = 1'b1;
                        waddr_d = '0;
                        wdata_d = pix;
                        if (sink_endofpacket) begin
                            ptr_d = '0;
                            if (ONE_PIX) begin
                                done_d  = 1'b1;
                                count_d = count_q + 8'd1;
                                state_d = freeze ? S_FROZEN : S_IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            ptr_d   = PTR_ONE;
                            state_d = S_WRITE;
                        end
                    end else if (state_q == S_DROP && sink_endofpacket) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (acc) begin
                    if (sink_startofpacket) begin
                        // restart mid-frame: flag the abandoned frame, keep the new pixel
                        err_d   = 1'b1;
                        wren_d  = 1'b1;
                        waddr_d = '0;
                        wdata_d = pix;
                        if (sink_endofpacket) begin
                            ptr_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            ptr_d = PTR_ONE;
                        end
                    end else if (ptr_q == PIX_FULL) begin
                        err_d   = 1'b1;
                        ptr_d   = '0;
                        state_d = sink_endofpacket ? S_IDLE : S_DROP;
                    end else begin
                        wren_d  = 1'b1;
                        waddr_d = ptr_q[ADDR_W-1:0];
                        wdata_d = pix;
                        if (sink_endofpacket) begin
                            ptr_d = '0;
                            if (ptr_q == PIX_LAST) begin
                                done_d  = 1'b1;
                                count_d = count_q + 8'd1;
                                state_d = freeze ? S_FROZEN : S_IDLE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            ptr_d = ptr_q + PTR_ONE;
                        end
                    end
                end
            end
            S_FROZEN: begin
                if (!freeze) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:         ready_d = ~freeze;
            S_WRITE, S_DROP: ready_d = 1'b1;
            default:        ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
            wren_q  <= wren_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign sink_ready  = ready_q;
    assign wren        = wren_q;
    assign wraddress   = waddr_q;
    assign wrdata      = wdata_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_avst_frame_writer.sv
// tb/tb_avst_frame_writer.sv - directed self-checking bench for avst_frame_writer (8x4 frame).
module tb_avst_frame_writer;

    localparam int COLS   = 8;
    localparam int ROWS   = 4;
    localparam int NPIX   = COLS * ROWS;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [29:0]       sink_data = '0;
    logic              sink_valid = 1'b0;
    logic              sink_ready;
    logic              sink_startofpacket = 1'b0;
    logic              sink_endofpacket = 1'b0;
    logic              freeze = 1'b0;
    logic [ADDR_W-1:0] wraddress;
    logic [11:0]       wrdata;
    logic              wren;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        frame_count;

    avst_frame_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(30)) dut (
        .clk(clk), .reset(reset),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_startofpacket(sink_startofpacket), .sink_endofpacket(sink_endofpacket),
        .freeze(freeze),
        .wraddress(wraddress), .wrdata(wrdata), .wren(wren),
        .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [11:0]       d;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  d0, e0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] pat(input int i);
        logic [9:0] r, g, b;
        r = 10'(i * 37 + 5);
        g = 10'(i * 91 + 3);
        b = 10'(i * 13 + 1);
        return {r, g, b};
    endfunction

    function automatic logic [11:0] exp_pix(input logic [29:0] d);
`ifdef FRAME_WRITER_GRAY_EN
        int y;
        y = (77 * int'(d[29:20]) + 150 * int'(d[19:10]) + 29 * int'(d[9:0])) >> 8;
        return {3{y[9:6]}};
`else
        return {d[29:26], d[19:16], d[9:6]};
`endif
    endfunction

    task automatic push_raw(input int addr, input logic [11:0] d);
        wr_t e;
        e.a = ADDR_W'(addr);
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the next expected write
    always @(negedge clk) begin
        if (wren) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {15'd0, wraddress}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {15'd0, wraddress}, {15'd0, e.a});
                check("wr_data", {20'd0, wrdata}, {20'd0, e.d});
            end
        end
        if (frame_done) begin
            done_cnt++;
            check("done_slot", {14'd0, wren, wraddress}, {14'd0, 1'b1, ADDR_W'(NPIX - 1)});
        end
        if (frame_err) err_cnt++;
        if (frame_done && frame_err) check("done_err_excl", 32'd1, 32'd0);
    end

    task automatic beat(input logic [29:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        sink_data          = d;
        sink_startofpacket = sop;
        sink_endofpacket   = eop;
        sink_valid         = 1'b1;
        while (!sink_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sink_ready) check("ready_timeout", {31'd0, sink_ready}, 32'd1);
        @(negedge clk);
        sink_valid         = 1'b0;
        sink_startofpacket = 1'b0;
        sink_endofpacket   = 1'b0;
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // n beats, SOP on beat 0, EOP on beat eop_idx (-1: none); beats past the frame are not expected
    task automatic send_frame(input int n, input int eop_idx, input bit gaps, input int freeze_at);
        for (int i = 0; i < n; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            if (i == freeze_at) freeze = 1'b1;
            if (i < NPIX) push_raw(i, exp_pix(pat(i)));
            beat(pat(i), i == 0, i == eop_idx);
        end
    endtask

    task automatic mark();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    task automatic expect_pulses(input string tag, input int dn, input int en, input int cnt);
        @(negedge clk);
        check({tag, "_done"}, 32'(done_cnt - d0), 32'(dn));
        check({tag, "_err"}, 32'(err_cnt - e0), 32'(en));
        check({tag, "_count"}, {24'd0, frame_count}, 32'(cnt));
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [29:0] v;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, sink_ready}, 32'd0);
        check("reset_wren", {31'd0, wren}, 32'd0);
        check("reset_addr", {15'd0, wraddress}, 32'd0);
        check("reset_data", {20'd0, wrdata}, 32'd0);
        check("reset_done", {31'd0, frame_done}, 32'd0);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        check("reset_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, sink_ready}, 32'd1);

        mark();
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("full", 1, 0, 1);

        mark();
        for (int i = 0; i < 10; i++) beat(pat(100 + i), 1'b0, 1'b0);
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("nosop", 1, 0, 2);

        mark();
        send_frame(11, 10, 1'b0, -1);
        expect_pulses("early_eop", 0, 1, 2);
        mark();
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("after_early", 1, 0, 3);

        mark();
        send_frame(NPIX + 6, NPIX + 5, 1'b0, -1);
        expect_pulses("overrun", 0, 1, 3);
        mark();
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("after_overrun", 1, 0, 4);

        mark();
        for (int i = 0; i < 10; i++) begin
            push_raw(i, exp_pix(pat(i)));
            beat(pat(i), i == 0, 1'b0);
        end
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("mid_sop", 1, 1, 5);

        mark();
`ifdef FRAME_WRITER_GRAY_EN
        v = {10'h3FC, 10'h3FC, 10'h3FC};
        push_raw(0, 12'hFFF);
        beat(v, 1'b1, 1'b1);
        v = {10'h000, 10'h3FC, 10'h000};
        push_raw(0, 12'h999);
        beat(v, 1'b1, 1'b1);
        expect_pulses("single_gray", 0, 2, 5);
`else
        v = {10'h3FC, 10'h155, 10'h2AA};
        push_raw(0, 12'hF5A);
        beat(v, 1'b1, 1'b1);
        v = {10'h0C0, 10'h3FF, 10'h040};
        push_raw(0, 12'h3F1);
        beat(v, 1'b1, 1'b1);
        expect_pulses("single_pack", 0, 2, 5);
`endif

        mark();
        send_frame(NPIX, NPIX - 1, 1'b1, 10);
        expect_pulses("freeze_frame", 1, 0, 6);
        sink_data          = pat(7);
        sink_startofpacket = 1'b1;
        sink_valid         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("frozen_ready", {31'd0, sink_ready}, 32'd0);
        end
        sink_valid         = 1'b0;
        sink_startofpacket = 1'b0;
        freeze             = 1'b0;
        @(negedge clk);
        check("unfrozen_ready", {31'd0, sink_ready}, 32'd1);
        mark();
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("after_freeze", 1, 0, 7);

        mark();
        send_frame(5, -1, 1'b0, -1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ready", {31'd0, sink_ready}, 32'd0);
        check("midreset_wren", {31'd0, wren}, 32'd0);
        check("midreset_addr", {15'd0, wraddress}, 32'd0);
        check("midreset_data", {20'd0, wrdata}, 32'd0);
        check("midreset_count", {24'd0, frame_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
        mark();
        send_frame(NPIX, NPIX - 1, 1'b0, -1);
        expect_pulses("after_reset", 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
